// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter output path.
package fir_pkg;

  localparam int BYTE_SIZE   = 8;
  localparam int PACKET_SIZE = 8;
  localparam int SAMPLES_NUM = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCALE  = 2'd1,
    COMMIT = 2'd2
  } packer_state_t;

endpackage

// File: rtl/fir_sample_scaler.sv
// Combinational round / arithmetic-shift / saturate of one signed filter result.
// The work is done at ACC_WIDTH+1 bits, so the rounding bias can never wrap.
module fir_sample_scaler #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT     = 0
) (
  input  logic [ACC_WIDTH-1:0] x,
  output logic [OUT_WIDTH-1:0] y,
  output logic                 satFlag
);

  logic signed [ACC_WIDTH:0] x_ext;
  logic signed [ACC_WIDTH:0] rounded;

  assign x_ext = {x[ACC_WIDTH-1], x};

  generate
    if (SHIFT == 0) begin : g_no_shift
      assign rounded = x_ext;
    end else begin : g_shift
      // Adding half an output LSB before the arithmetic shift gives round-half-up.
      localparam logic signed [ACC_WIDTH:0] ROUND_BIAS = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
      logic signed [ACC_WIDTH:0] biased;
      assign biased  = x_ext + ROUND_BIAS;
      assign rounded = biased >>> SHIFT;
    end

    if (OUT_WIDTH > ACC_WIDTH) begin : g_wide_out
      // The output is wide enough for any rounded value: plain sign extension.
      assign y       = OUT_WIDTH'(rounded);
      assign satFlag = 1'b0;
    end else begin : g_clamp
      // The value fits when every bit from the output sign bit upwards agrees.
      logic [ACC_WIDTH-OUT_WIDTH+1:0] upper_bits;
      logic                           fits;
      assign upper_bits = rounded[ACC_WIDTH:OUT_WIDTH-1];
      assign fits       = (&upper_bits) | ~(|upper_bits);
      assign satFlag    = ~fits;
      assign y = fits                ? rounded[OUT_WIDTH-1:0] :
                 rounded[ACC_WIDTH]  ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                                       {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  endgenerate

endmodule

// File: rtl/fir_result_packer.sv
// Packs one filter run into an SPI-sized packet, one scaled sample per cycle,
// and double-buffers the result so the SPI transmit path only ever sees whole packets.
module fir_result_packer
  import fir_pkg::*;
#(
  parameter int PACKET_SIZE = fir_pkg::PACKET_SIZE,
  parameter int SAMPLES_NUM = fir_pkg::SAMPLES_NUM,
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 32,
  parameter int SHIFT       = 0,
  localparam int PW         = PACKET_SIZE * BYTE_SIZE
) (
  input  logic                             clk,
  input  logic                             nResetIn,
  input  logic                             resultValidIn,
  input  logic [SAMPLES_NUM*ACC_WIDTH-1:0] resultIn,
  input  logic                             packetDoneIn,
  input  logic                             statusClearIn,
  output logic [PW-1:0]                    txDataOut,
  output logic                             busyOut,
  output logic                             overrunOut,
  output logic                             dropOut,
  output logic                             underrunOut,
  output logic                             satOut
);

  localparam int                IDX_W    = (SAMPLES_NUM > 1) ? $clog2(SAMPLES_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_NUM - 1);

  packer_state_t                    state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [SAMPLES_NUM*ACC_WIDTH-1:0] in_q, in_d;
  logic [PW-1:0]                    stage_q, stage_d;
  logic [PW-1:0]                    ready_q, ready_d;
  logic                             ready_flag_q, ready_flag_d;
  logic [PW-1:0]                    tx_q, tx_d;
  logic                             busy_q, busy_d;
  logic                             overrun_q, overrun_d;
  logic                             drop_q, drop_d;
  logic                             underrun_q, underrun_d;
  logic                             sat_q, sat_d;

  logic [ACC_WIDTH-1:0] samples [SAMPLES_NUM];
  logic [ACC_WIDTH-1:0] cur_sample;
  logic [OUT_WIDTH-1:0] scaled;
  logic                 scaled_sat;
  logic                 commit;

  // Sample 0 sits in the MSBs of the captured result word.
  generate
    for (genvar gi = 0; gi < SAMPLES_NUM; gi++) begin : g_samples
      assign samples[gi] = in_q[(SAMPLES_NUM-1-gi)*ACC_WIDTH +: ACC_WIDTH];
    end
  endgenerate

  // Select the sample addressed by idx for the shared scaler.
  always_comb begin
    cur_sample = '0;
    for (int s = 0; s < SAMPLES_NUM; s++) begin
      if (idx_q == IDX_W'(s)) cur_sample = samples[s];
    end
  end

  fir_sample_scaler #(
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT)
  ) u_scaler (
    .x      (cur_sample),
    .y      (scaled),
    .satFlag(scaled_sat)
  );

  assign commit = (state_q == COMMIT);

  // Next-state logic: FSM, staging, double buffer, transmit register and sticky status.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    in_d         = in_q;
    stage_d      = stage_q;
    ready_d      = ready_q;
    ready_flag_d = ready_flag_q;
    tx_d         = tx_q;
    // Clear first so that a same-cycle event below re-sets its bit.
    overrun_d    = statusClearIn ? 1'b0 : overrun_q;
    drop_d       = statusClearIn ? 1'b0 : drop_q;
    underrun_d   = statusClearIn ? 1'b0 : underrun_q;
    sat_d        = statusClearIn ? 1'b0 : sat_q;

    case (state_q)
      IDLE: begin
        if (resultValidIn) begin
          in_d    = resultIn;
          idx_d   = '0;
          stage_d = '0;
          state_d = SCALE;
        end
      end
      SCALE: begin
        for (int s = 0; s < SAMPLES_NUM; s++) begin
          if (idx_q == IDX_W'(s)) stage_d[PW-1-s*OUT_WIDTH -: OUT_WIDTH] = scaled;
        end
        if (scaled_sat) sat_d = 1'b1;
        if (idx_q == LAST_IDX) state_d = COMMIT;
        else                   idx_d   = idx_q + 1'b1;
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new run cannot be accepted while the previous one is still being packed.
    if (resultValidIn && (state_q != IDLE)) overrun_d = 1'b1;

    // Packet boundary: hand over the waiting packet, the one being committed
    // right now, or zeros; an already-sent packet is never repeated.
    if (packetDoneIn) begin
      if (ready_flag_q) begin
        tx_d         = ready_q;
        ready_flag_d = 1'b0;
      end else if (commit) begin
        tx_d = stage_q;
      end else begin
        tx_d       = '0;
        underrun_d = 1'b1;
      end
    end

    // Commit into the ready buffer unless the packet was just bypassed to tx.
    // If the boundary consumed the old ready packet this cycle, nothing is lost.
    if (commit && !(packetDoneIn && !ready_flag_q)) begin
      ready_d      = stage_q;
      ready_flag_d = 1'b1;
      if (ready_flag_q && !packetDoneIn) drop_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nResetIn) begin
    if (!nResetIn) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      in_q         <= '0;
      stage_q      <= '0;
      ready_q      <= '0;
      ready_flag_q <= 1'b0;
      tx_q         <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      drop_q       <= 1'b0;
      underrun_q   <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      in_q         <= in_d;
      stage_q      <= stage_d;
      ready_q      <= ready_d;
      ready_flag_q <= ready_flag_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      drop_q       <= drop_d;
      underrun_q   <= underrun_d;
      sat_q        <= sat_d;
    end
  end

  assign txDataOut   = tx_q;
  assign busyOut     = busy_q;
  assign overrunOut  = overrun_q;
  assign dropOut     = drop_q;
  assign underrunOut = underrun_q;
  assign satOut      = sat_q;

endmodule
